// File: rtl/systolic_mac_node_dbuf.sv
`default_nettype none
// ============================================================================
// Module   : systolic_mac_node_dbuf
// Purpose  : Weight-stationary systolic PE with double-buffered weights, a
//            three-stage MAC pipeline, rounding/saturation and sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_mac_node_dbuf #(
    parameter int FIXED_POINT_WIDTH     = 16,
    parameter int FIXED_POINT_POSITION  = 10,
    parameter int PARTIAL_SUM_WIDTH_IN  = 16,
    parameter int PARTIAL_SUM_WIDTH_OUT = 17,
    parameter int ROUND_ENABLE          = 1
) (
    input  logic                                    clk_in,
    input  logic                                    rst_n_in,
    input  logic                                    weight_load_in,
    input  logic signed [FIXED_POINT_WIDTH-1:0]     weight_in,
    input  logic                                    weight_swap_in,
    input  logic                                    activation_valid_in,
    input  logic signed [FIXED_POINT_WIDTH-1:0]     activation_in,
    input  logic signed [PARTIAL_SUM_WIDTH_IN-1:0]  partial_sum_in,
    input  logic                                    sat_clear_in,
    output logic                                    activation_valid_out,
    output logic signed [FIXED_POINT_WIDTH-1:0]     activation_out,
    output logic                                    partial_sum_valid_out,
    output logic signed [PARTIAL_SUM_WIDTH_OUT-1:0] partial_sum_out,
    output logic                                    product_sat_flag_out,
    output logic                                    sum_sat_flag_out
);

    localparam int FW  = FIXED_POINT_WIDTH;
    localparam int PW  = 2 * FIXED_POINT_WIDTH;
    localparam int PSI = PARTIAL_SUM_WIDTH_IN;
    localparam int PSO = PARTIAL_SUM_WIDTH_OUT;

    localparam logic signed [PW:0] c_PMAX = {{(PW-FW+2){1'b0}}, {(FW-1){1'b1}}};
    localparam logic signed [PW:0] c_PMIN = {{(PW-FW+2){1'b1}}, {(FW-1){1'b0}}};
    localparam logic signed [PW:0] c_RND  = (ROUND_ENABLE != 0) ?
        ({{PW{1'b0}}, 1'b1} << (FIXED_POINT_POSITION - 1)) : '0;
    localparam logic signed [PSO:0] c_SMAX = {2'b00, {(PSO-1){1'b1}}};
    localparam logic signed [PSO:0] c_SMIN = {2'b11, {(PSO-1){1'b0}}};

    logic signed [FW-1:0]  r_shadow;
    logic signed [FW-1:0]  r_active;
    logic                  r_s1_valid;
    logic signed [FW-1:0]  r_s1_act;
    logic signed [PSI-1:0] r_s1_psum;
    logic                  r_s2_valid;
    logic signed [PW-1:0]  r_s2_prod;
    logic signed [PSI-1:0] r_s2_psum;
    logic                  r_out_valid;
    logic signed [PSO-1:0] r_out_psum;
    logic                  r_psat;
    logic                  r_ssat;

    logic signed [PW-1:0]  w_mult;
    logic signed [PW:0]    w_prod_rnd;
    logic signed [PW:0]    w_prod_shift;
    logic signed [FW-1:0]  w_prod_rect;
    logic                  w_prod_sat;
    logic signed [PSO:0]   w_sum;
    logic signed [PSO-1:0] w_sum_rect;
    logic                  w_sum_sat;

    // Operands widened first so the product keeps full precision.
    assign w_mult = $signed({{FW{r_active[FW-1]}}, r_active}) *
                    $signed({{FW{r_s1_act[FW-1]}}, r_s1_act});

    assign w_prod_rnd   = $signed({r_s2_prod[PW-1], r_s2_prod}) + c_RND;
    assign w_prod_shift = w_prod_rnd >>> FIXED_POINT_POSITION;

    always_comb begin
        w_prod_rect = w_prod_shift[FW-1:0];
        w_prod_sat  = 1'b0;
        if (w_prod_shift > c_PMAX) begin
            w_prod_rect = c_PMAX[FW-1:0];
            w_prod_sat  = 1'b1;
        end else if (w_prod_shift < c_PMIN) begin
            w_prod_rect = c_PMIN[FW-1:0];
            w_prod_sat  = 1'b1;
        end
    end

    assign w_sum = $signed({{(PSO+1-FW){w_prod_rect[FW-1]}}, w_prod_rect}) +
                   $signed({{(PSO+1-PSI){r_s2_psum[PSI-1]}}, r_s2_psum});

    always_comb begin
        w_sum_rect = w_sum[PSO-1:0];
        w_sum_sat  = 1'b0;
        if (w_sum > c_SMAX) begin
            w_sum_rect = c_SMAX[PSO-1:0];
            w_sum_sat  = 1'b1;
        end else if (w_sum < c_SMIN) begin
            w_sum_rect = c_SMIN[PSO-1:0];
            w_sum_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_shadow    <= '0;
            r_active    <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_act    <= '0;
            r_s1_psum   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_prod   <= '0;
            r_s2_psum   <= '0;
            r_out_valid <= 1'b0;
            r_out_psum  <= '0;
            r_psat      <= 1'b0;
            r_ssat      <= 1'b0;
        end else begin
            if (weight_load_in) begin
                r_shadow <= weight_in;
            end
            // Simultaneous load+swap forwards the new weight straight to active.
            if (weight_swap_in) begin
                r_active <= weight_load_in ? weight_in : r_shadow;
            end

            r_s1_valid <= activation_valid_in;
            r_s1_act   <= activation_in;
            r_s1_psum  <= partial_sum_in;

            r_s2_valid <= r_s1_valid;
            r_s2_prod  <= w_mult;
            r_s2_psum  <= r_s1_psum;

            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_psum <= w_sum_rect;
            end

            r_psat <= (r_psat & ~sat_clear_in) | (r_s2_valid & w_prod_sat);
            r_ssat <= (r_ssat & ~sat_clear_in) | (r_s2_valid & w_sum_sat);
        end
    end

    assign activation_valid_out  = r_s1_valid;
    assign activation_out        = r_s1_act;
    assign partial_sum_valid_out = r_out_valid;
    assign partial_sum_out       = r_out_psum;
    assign product_sat_flag_out  = r_psat;
    assign sum_sat_flag_out      = r_ssat;

endmodule
`default_nettype wire

// File: tb/tb_systolic_mac_node_dbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_mac_node_dbuf
// Purpose  : Directed + random bench for two PE configurations against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_mac_node_dbuf;

    typedef struct {
        bit v;
        int ps;
        bit psat;
        bit ssat;
    } beat_t;

    logic clk;
    logic rst_n;
    logic ld, sw, vin, clr;
    logic signed [15:0] w_in, a_in, ps_in;

    logic               av0, av1, pv0, pv1, pf0, pf1, sf0, sf1;
    logic signed [15:0] ao0, ao1;
    logic signed [16:0] ps0;
    logic signed [15:0] ps1;

    int n_checks = 0;
    int n_err    = 0;

    // Model state (index 0: rounding, 17-bit sum; index 1: truncation, 16-bit sum)
    int    m_shadow, m_active;
    int    m_ao;
    bit    m_av;
    beat_t d1[2], d2[2];
    bit    m_pv[2], m_pf[2], m_sf[2];
    int    m_ps[2];
    int    c_round[2] = '{1, 0};
    int    c_psw[2]   = '{17, 16};

    systolic_mac_node_dbuf #(
        .FIXED_POINT_WIDTH(16), .FIXED_POINT_POSITION(10),
        .PARTIAL_SUM_WIDTH_IN(16), .PARTIAL_SUM_WIDTH_OUT(17), .ROUND_ENABLE(1)
    ) dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .weight_load_in(ld), .weight_in(w_in),
        .weight_swap_in(sw), .activation_valid_in(vin), .activation_in(a_in),
        .partial_sum_in(ps_in), .sat_clear_in(clr),
        .activation_valid_out(av0), .activation_out(ao0),
        .partial_sum_valid_out(pv0), .partial_sum_out(ps0),
        .product_sat_flag_out(pf0), .sum_sat_flag_out(sf0)
    );

    systolic_mac_node_dbuf #(
        .FIXED_POINT_WIDTH(16), .FIXED_POINT_POSITION(10),
        .PARTIAL_SUM_WIDTH_IN(16), .PARTIAL_SUM_WIDTH_OUT(16), .ROUND_ENABLE(0)
    ) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .weight_load_in(ld), .weight_in(w_in),
        .weight_swap_in(sw), .activation_valid_in(vin), .activation_in(a_in),
        .partial_sum_in(ps_in), .sat_clear_in(clr),
        .activation_valid_out(av1), .activation_out(ao1),
        .partial_sum_valid_out(pv1), .partial_sum_out(ps1),
        .product_sat_flag_out(pf1), .sum_sat_flag_out(sf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Fixed-point MAC computed directly from the arithmetic rules.
    function automatic beat_t calc(int w, int a, int ps, int rnd, int psw);
        beat_t  b;
        longint p, s, smax, smin;
        p = longint'(w) * longint'(a);
        if (rnd != 0) p = p + 512;
        p = p >>> 10;
        b.psat = (p > 32767) || (p < -32768);
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        smax = (longint'(1) <<< (psw - 1)) - 1;
        smin = -(longint'(1) <<< (psw - 1));
        s = p + longint'(ps);
        b.ssat = (s > smax) || (s < smin);
        if (s > smax) s = smax;
        if (s < smin) s = smin;
        b.ps = int'(s);
        b.v  = 1'b0;
        return b;
    endfunction

    task automatic model_reset();
        m_shadow = 0; m_active = 0; m_ao = 0; m_av = 0;
        for (int d = 0; d < 2; d++) begin
            d1[d] = '{0, 0, 0, 0};
            d2[d] = '{0, 0, 0, 0};
            m_pv[d] = 0; m_pf[d] = 0; m_sf[d] = 0; m_ps[d] = 0;
        end
    endtask

    task automatic model_edge();
        beat_t nb, old;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (sw) m_active = ld ? int'(w_in) : m_shadow;
        if (ld) m_shadow = int'(w_in);
        m_ao = int'(a_in);
        m_av = vin;
        for (int d = 0; d < 2; d++) begin
            nb   = calc(m_active, int'(a_in), int'(ps_in), c_round[d], c_psw[d]);
            nb.v = vin;
            old  = d2[d];
            d2[d] = d1[d];
            d1[d] = nb;
            m_pf[d] = (m_pf[d] && !clr) || (old.v && old.psat);
            m_sf[d] = (m_sf[d] && !clr) || (old.v && old.ssat);
            m_pv[d] = old.v;
            if (old.v) m_ps[d] = old.ps;
        end
    endtask

    task automatic chk(string tag, int obs, int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("ao0", int'(ao0), m_ao);  chk("av0", int'(av0), int'(m_av));
        chk("ao1", int'(ao1), m_ao);  chk("av1", int'(av1), int'(m_av));
        chk("pv0", int'(pv0), int'(m_pv[0])); chk("ps0", int'(ps0), m_ps[0]);
        chk("pf0", int'(pf0), int'(m_pf[0])); chk("sf0", int'(sf0), int'(m_sf[0]));
        chk("pv1", int'(pv1), int'(m_pv[1])); chk("ps1", int'(ps1), m_ps[1]);
        chk("pf1", int'(pf1), int'(m_pf[1])); chk("sf1", int'(sf1), int'(m_sf[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        ld = 0; sw = 0; vin = 0; clr = 0; w_in = '0; a_in = '0; ps_in = '0;
    endtask

    // One beat with a bypassed weight; returns once its result is visible.
    task automatic beat(int w, int a, int ps);
        ld = 1; sw = 1; w_in = 16'(w); vin = 1; a_in = 16'(a); ps_in = 16'(ps);
        step();
        idle_inputs();
        step();
        step();
    endtask

    int sw_ld[8]  = '{1, 1, 0, 0, 0, 1, 0, 0};
    int sw_sw[8]  = '{1, 0, 0, 0, 1, 1, 0, 0};
    int sw_w[8]   = '{1024, 2048, 0, 0, 0, 512, 0, 0};
    int sw_exp[8] = '{1024, 1024, 1024, 1024, 2048, 512, 512, 512};

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        #12;
        compare_all();
        #10 rst_n = 1;

        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_pv", int'(pv0), 0);
            chk("idle_ps", int'(ps0), 0);
            chk("idle_av", int'(av0), 0);
        end

        // Basic MAC: 1.5 * 2.0 + 100
        ld = 1; w_in = 16'sd1536; step();
        ld = 0; sw = 1; step();
        sw = 0; vin = 1; a_in = 16'sd2048; ps_in = 16'sd100; step();
        chk("act_lat", int'(ao0), 2048);
        idle_inputs(); step(); step();
        chk("mac_ps", int'(ps0), 3172);
        chk("mac_pv", int'(pv0), 1);
        chk("mac_pf", int'(pf0), 0);
        chk("mac_sf", int'(sf0), 0);
        step();
        chk("hold_pv", int'(pv0), 0);
        chk("hold_ps", int'(ps0), 3172);

        // Rounding versus truncation
        beat(1, 512, 0);
        chk("rnd_pos", int'(ps0), 1);
        chk("trn_pos", int'(ps1), 0);
        beat(-1, 512, 0);
        chk("rnd_neg", int'(ps0), 0);
        chk("trn_neg", int'(ps1), -1);

        // Product saturation and sticky flag
        beat(32767, 32767, 0);
        chk("psat_hi", int'(ps0), 32767);
        chk("psat_f", int'(pf0), 1);
        beat(-32768, 32767, 0);
        chk("psat_lo", int'(ps1), -32768);
        step(); step();
        chk("psat_hold", int'(pf0), 1);
        clr = 1; step(); clr = 0;
        chk("psat_clr", int'(pf0), 0);
        ld = 1; sw = 1; w_in = 16'sd32767; vin = 1; a_in = 16'sd32767; step();
        idle_inputs(); step();
        clr = 1; step(); clr = 0;
        chk("clr_vs_sat", int'(pf0), 1);

        // Sum saturation in the 16-bit output instance
        beat(1536, 2048, 32000);
        chk("ssat_hi", int'(ps1), 32767);
        chk("ssat_f", int'(sf1), 1);
        chk("wide_hi", int'(ps0), 35072);
        chk("wide_sf", int'(sf0), 0);
        beat(-1536, 2048, -32000);
        chk("ssat_lo", int'(ps1), -32768);
        chk("wide_lo", int'(ps0), -35072);
        clr = 1; step(); clr = 0;

        // Shadow/active swap while streaming
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                ld = sw_ld[i][0]; sw = sw_sw[i][0]; w_in = 16'(sw_w[i]);
                vin = 1; a_in = 16'sd1024; ps_in = '0;
            end else begin
                idle_inputs();
            end
            step();
            if (i >= 2) begin
                chk("swap_ps", int'(ps0), sw_exp[i-2]);
                chk("swap_pv", int'(pv0), 1);
            end
        end
        idle_inputs();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ld    = ($urandom_range(0, 3) == 0);
            sw    = ($urandom_range(0, 4) == 0);
            w_in  = 16'($urandom);
            vin   = ($urandom_range(0, 3) != 0);
            a_in  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($signed(12'($urandom)));
            ps_in = 16'($urandom);
            clr   = ($urandom_range(0, 9) == 0);
            step();
        end

        // Reset with beats in flight
        ld = 1; sw = 1; w_in = 16'sd1024; vin = 1; a_in = 16'sd1024; ps_in = 16'sd7;
        step();
        step();
        #2 rst_n = 0;
        model_reset();
        #1;
        compare_all();
        chk("rst_pv", int'(pv0), 0);
        chk("rst_ps", int'(ps0), 0);
        chk("rst_av", int'(av0), 0);
        idle_inputs();
        #1 rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_pv", int'(pv0), 0);
            chk("post_rst_pv1", int'(pv1), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
